// File: rtl/zoom_line_reader.sv
// Nearest-neighbour upscaler on the read side of the line buffer: repeats each pixel
// ZOOM_FACTOR times and asks the manager to replay each line ZOOM_FACTOR times.
module zoom_line_reader #(
  parameter int LINE_DEPTH  = 4,
  parameter int PIXEL_WIDTH = 8,
  parameter int ZOOM_FACTOR = 2,
  parameter int LINE_COUNT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_data,
  output logic                   repeat_line,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_data,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   out_eof
);

  localparam int HW = (ZOOM_FACTOR > 1) ? $clog2(ZOOM_FACTOR) : 1;
  localparam int CW = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
  localparam int RW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;

  localparam logic [HW-1:0] Z_LAST = HW'(ZOOM_FACTOR - 1);
  localparam logic [CW-1:0] C_LAST = CW'(LINE_DEPTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(LINE_COUNT - 1);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]             state;
  logic [HW-1:0]          h_cnt;
  logic [HW-1:0]          v_cnt;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [PIXEL_WIDTH-1:0] hold_data;
  logic                   first_col_tag;
  logic                   last_col_tag;
  logic                   last_line_tag;

  logic hold_valid;
  logic h_last;
  logic accept;
  logic out_fire;
  logic line_wrap;

  assign hold_valid = (state == HOLD);
  assign h_last     = (h_cnt == Z_LAST);
  assign in_ready   = !hold_valid || (out_ready && h_last);
  assign accept     = in_valid && in_ready;
  assign out_fire   = hold_valid && out_ready;
  assign line_wrap  = (col == C_LAST);

  // Rewind request rides on the last-pixel handshake of every replica except the final one.
  assign repeat_line = accept && line_wrap && (v_cnt != Z_LAST);

  assign out_valid = hold_valid;
  assign out_data  = hold_data;
  assign out_sof   = hold_valid && first_col_tag && (h_cnt == '0);
  assign out_eol   = hold_valid && last_col_tag && h_last;
  assign out_eof   = out_eol && last_line_tag;

  // A new pixel can only land on the final replica of the old one, so accept takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= EMPTY;
      h_cnt         <= '0;
      hold_data     <= '0;
      first_col_tag <= 1'b0;
      last_col_tag  <= 1'b0;
      last_line_tag <= 1'b0;
    end else if (accept) begin
      state         <= HOLD;
      h_cnt         <= '0;
      hold_data     <= in_data;
      first_col_tag <= (col == '0) && (v_cnt == '0) && (row == '0);
      last_col_tag  <= line_wrap;
      last_line_tag <= (v_cnt == Z_LAST) && (row == R_LAST);
    end else if (out_fire) begin
      if (h_last) begin
        h_cnt <= '0;
        state <= EMPTY;
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Input position: column within the line, replica of the line, and line within the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col   <= '0;
      v_cnt <= '0;
      row   <= '0;
    end else if (accept) begin
      if (line_wrap) begin
        col <= '0;
        if (v_cnt != Z_LAST) begin
          v_cnt <= v_cnt + HW'(1);
        end else begin
          v_cnt <= '0;
          row   <= (row == R_LAST) ? '0 : row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_zoom_line_reader.sv
// Randomized bench for zoom_line_reader: the bench plays the line-buffer manager and
// predicts the upscaled stream from frame/line/pixel arithmetic.
module tb_zoom_line_reader;

  localparam int D  = 4;
  localparam int PW = 8;
  localparam int L  = 2;
  localparam int NF = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [PW-1:0] in_data;
  logic          out_ready;

  logic          in_ready_a, repeat_a, out_valid_a, sof_a, eol_a, eof_a;
  logic [PW-1:0] out_data_a;
  logic          in_ready_b, repeat_b, out_valid_b, sof_b, eol_b, eof_b;
  logic [PW-1:0] out_data_b;

  int zsel = 2;
  logic          o_in_ready, o_repeat, o_out_valid, o_sof, o_eol, o_eof;
  logic [PW-1:0] o_out_data;

  int tests = 0;
  int fails = 0;

  logic [PW-1:0] pix [NF][L][D];

  always #5 clk = ~clk;

  zoom_line_reader #(.LINE_DEPTH(D), .PIXEL_WIDTH(PW), .ZOOM_FACTOR(2), .LINE_COUNT(L)) dut_z2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .repeat_line(repeat_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_sof(sof_a), .out_eol(eol_a), .out_eof(eof_a)
  );

  zoom_line_reader #(.LINE_DEPTH(D), .PIXEL_WIDTH(PW), .ZOOM_FACTOR(1), .LINE_COUNT(L)) dut_z1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .repeat_line(repeat_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_sof(sof_b), .out_eol(eol_b), .out_eof(eof_b)
  );

  assign o_in_ready  = (zsel == 1) ? in_ready_b  : in_ready_a;
  assign o_repeat    = (zsel == 1) ? repeat_b    : repeat_a;
  assign o_out_valid = (zsel == 1) ? out_valid_b : out_valid_a;
  assign o_out_data  = (zsel == 1) ? out_data_b  : out_data_a;
  assign o_sof       = (zsel == 1) ? sof_b       : sof_a;
  assign o_eol       = (zsel == 1) ? eol_b       : eol_a;
  assign o_eof       = (zsel == 1) ? eof_b       : eof_a;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Frame 0 uses the familiar 10..13 / 20..23 lines; frame 1 starts with 30.
  task automatic fill_plan();
    for (int f = 0; f < NF; f++)
      for (int l = 0; l < L; l++)
        for (int d = 0; d < D; d++)
          pix[f][l][d] = PW'($urandom);
    for (int d = 0; d < D; d++) begin
      pix[0][0][d] = PW'(10 + d);
      pix[0][1][d] = PW'(20 + d);
      pix[1][0][d] = PW'(30 + d);
    end
  endtask

  // The manager feeds every line z times in a row.
  function automatic logic [PW-1:0] in_pixel(input int z, input int k);
    int per, r;
    per = L * z * D;
    r   = k % per;
    return pix[k / per][r / (z * D)][r % D];
  endfunction

  task automatic apply_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #3;
    check_output("rst_out_valid", o_out_valid, 0);
    check_output("rst_in_ready", o_in_ready, 1);
    check_output("rst_repeat", o_repeat, 0);
    check_output("rst_out_data", o_out_data, 0);
    check_output("rst_markers", {o_sof, o_eol, o_eof}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input int z, input int pv, input int pr, input int n_stop,
                                input bit stream_chk);
    int k = 0, n = 0, cyc = 0;
    int total_in, per, r, ol, op;
    bit seen = 0, prev_stall = 0, acc, fire, exp_rdy, exp_rep;
    logic [PW-1:0] prev_data = '0;
    zsel     = z;
    total_in = NF * L * z * D;
    per      = L * z * D * z;
    while (n < n_stop && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      in_valid  = (k < total_in) && ($urandom_range(99) < pv);
      in_data   = in_valid ? in_pixel(z, k) : PW'($urandom);
      out_ready = ($urandom_range(99) < pr);
      #1;
      if (prev_stall) begin
        check_output("stall_valid", o_out_valid, 1);
        check_output("stall_data", o_out_data, prev_data);
      end
      acc  = in_valid && o_in_ready;
      fire = o_out_valid && out_ready;
      if (!o_out_valid)    exp_rdy = 1'b1;
      else if (!out_ready) exp_rdy = 1'b0;
      else                 exp_rdy = ((n % z) == z - 1);
      check_output("in_ready", o_in_ready, exp_rdy);
      exp_rep = acc && ((k % D) == D - 1) && (((k / D) % z) != z - 1);
      check_output("repeat_line", o_repeat, exp_rep);
      if (stream_chk && seen) check_output("no_bubble", o_out_valid, 1);
      if (fire) begin
        r  = n % per;
        ol = r / (D * z);
        op = r % (D * z);
        check_output("out_data", o_out_data, pix[n / per][ol / z][op / z]);
        check_output("out_sof", o_sof, (r == 0));
        check_output("out_eol", o_eol, (op == D * z - 1));
        check_output("out_eof", o_eof, (op == D * z - 1) && (ol == L * z - 1));
        n++;
        seen = 1'b1;
      end
      if (acc) k++;
      prev_stall = o_out_valid && !out_ready;
      prev_data  = o_out_data;
    end
    if (n < n_stop) check_output("timeout_outputs", n, n_stop);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int z2_all, z1_all;
    z2_all = NF * L * 2 * D * 2;
    z1_all = NF * L * D;
    fill_plan();

    apply_reset();
    apply_stimulus(2, 100, 100, z2_all, 1'b1);

    apply_reset();
    apply_stimulus(2, 70, 60, z2_all, 1'b0);

    apply_reset();
    apply_stimulus(2, 90, 30, z2_all, 1'b0);

    // Interrupt after the second replica of 11, then restart from frame start.
    apply_reset();
    apply_stimulus(2, 100, 100, 4, 1'b0);
    apply_reset();
    apply_stimulus(2, 80, 80, z2_all, 1'b0);

    apply_reset();
    apply_stimulus(1, 100, 100, z1_all, 1'b1);

    apply_reset();
    apply_stimulus(1, 60, 50, z1_all, 1'b0);

    fill_plan();
    apply_reset();
    apply_stimulus(2, 50, 70, z2_all, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
